multicycle_ctrl: RTL and testbench

Multicycle control unit for the RV32I core: a Moore-style FSM with a Mealy branch term that sequences a shared ALU/memory datapath across fetch, decode, execute, memory and writeback cycles. It replaces the single-cycle `ctrl` decoder when instruction and data memory are merged behind a single port. Memory accesses stall on a `mem_ready` handshake. Unsupported opcodes park the FSM in a trap state.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/alu_dec.sv | 31 +++
 rtl/multicycle_ctrl.sv | 148 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I control units: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, never on the FSM state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder shared by the single-cycle and multicycle control units.
module alu_dec
    import ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ADD: alucontrol = ALU_ADD;
            SUB: alucontrol = ALU_SUB;
            FUNCT: begin
                case (funct3)
                    // op5 separates R-type from immediates, so ADDI never subtracts.
                    3'b000:  alucontrol = (op5 & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing a shared ALU/memory datapath with a
// single memory port; memory states stall on mem_ready, unknown opcodes trap.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_t state_reg;
    state_t state_next;
    aluop_t aluop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        aluop      = ADD;
        illegal    = 1'b0;

        case (state_reg)
            FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // Enables are masked by rst_n so nothing latches while reset is held.
                if (mem_ready) begin
                    IRWrite    = rst_n;
                    PCWrite    = rst_n;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                aluop      = FUNCT;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                aluop      = FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                // Link value OldPC+4 is computed now; PC loads the target left in ALUOut.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                aluop      = SUB;
                PCWrite    = Zero;
                state_next = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign ImmSrc = imm_src(op);

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7     (funct7),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class
// cycle by cycle and compares the packed control word against hand-derived values.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,illegal}
    logic [14:0] ctrl_word;
    assign ctrl_word = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                        ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal};

    localparam logic [14:0] V_FETCH    = 15'b1_0_0_1_0_10_00_10_000_0;
    localparam logic [14:0] V_FSTALL   = 15'b0_0_0_0_0_10_00_10_000_0;
    localparam logic [14:0] V_DECODE   = 15'b0_0_0_0_0_00_01_01_000_0;
    localparam logic [14:0] V_MEMADR   = 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_MEMREAD  = 15'b0_1_0_0_0_00_00_00_000_0;
    localparam logic [14:0] V_MEMWB    = 15'b0_0_0_0_1_01_00_00_000_0;
    localparam logic [14:0] V_MEMWRITE = 15'b0_1_1_0_0_00_00_00_000_0;
    localparam logic [14:0] V_EXECR_SUB= 15'b0_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_EXECR_SLT= 15'b0_0_0_0_0_00_10_00_101_0;
    localparam logic [14:0] V_EXECI_ADD= 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_EXECI_OR = 15'b0_0_0_0_0_00_10_01_011_0;
    localparam logic [14:0] V_ALUWB    = 15'b0_0_0_0_1_00_00_00_000_0;
    localparam logic [14:0] V_JAL      = 15'b1_0_0_0_1_00_01_10_000_0;
    localparam logic [14:0] V_BEQ_T    = 15'b1_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_BEQ_NT   = 15'b0_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_TRAP     = 15'b0_0_0_0_0_00_00_00_000_1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Called at posedge+1; samples mid-cycle, then advances one clock.
    task automatic cycle(input string tag, input logic [14:0] exp);
        #4;
        check(tag, {17'd0, ctrl_word}, {17'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op     = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);

        // Reset held with mem_ready=1: FETCH decode with enables masked.
        @(posedge clk);
        #1;
        @(posedge clk);
        #4;
        check("rst_word", {17'd0, ctrl_word}, {17'd0, V_FSTALL});
        check("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw, no stall: 5 cycles.
        cycle("lw_fetch", V_FETCH);
        check("lw_imm", {30'd0, ImmSrc}, 32'd0);
        cycle("lw_decode", V_DECODE);
        cycle("lw_memadr", V_MEMADR);
        cycle("lw_memread", V_MEMREAD);
        cycle("lw_memwb", V_MEMWB);

        // sw with two stall cycles in MEMWRITE.
        set_instr(7'b0100011, 3'b010, 1'b0);
        cycle("sw_fetch", V_FETCH);
        check("sw_imm", {30'd0, ImmSrc}, 32'd1);
        cycle("sw_decode", V_DECODE);
        cycle("sw_memadr", V_MEMADR);
        mem_ready = 1'b0;
        cycle("sw_memwr0", V_MEMWRITE);
        cycle("sw_memwr1", V_MEMWRITE);
        mem_ready = 1'b1;
        cycle("sw_memwr2", V_MEMWRITE);

        // R-type sub.
        set_instr(7'b0110011, 3'b000, 1'b1);
        cycle("sub_fetch", V_FETCH);
        cycle("sub_decode", V_DECODE);
        cycle("sub_execr", V_EXECR_SUB);
        cycle("sub_aluwb", V_ALUWB);

        // addi with funct7=1 must still add.
        set_instr(7'b0010011, 3'b000, 1'b1);
        cycle("addi_fetch", V_FETCH);
        cycle("addi_decode", V_DECODE);
        cycle("addi_execi", V_EXECI_ADD);
        cycle("addi_aluwb", V_ALUWB);

        // slt (R) and ori (I) decode paths.
        set_instr(7'b0110011, 3'b010, 1'b0);
        cycle("slt_fetch", V_FETCH);
        cycle("slt_decode", V_DECODE);
        cycle("slt_execr", V_EXECR_SLT);
        cycle("slt_aluwb", V_ALUWB);
        set_instr(7'b0010011, 3'b110, 1'b0);
        cycle("ori_fetch", V_FETCH);
        cycle("ori_decode", V_DECODE);
        cycle("ori_execi", V_EXECI_OR);
        cycle("ori_aluwb", V_ALUWB);

        // beq taken; Zero high outside BEQ has no effect.
        set_instr(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b1;
        cycle("beqt_fetch", V_FETCH);
        check("beq_imm", {30'd0, ImmSrc}, 32'd2);
        cycle("beqt_decode", V_DECODE);
        cycle("beqt_beq", V_BEQ_T);
        // beq not taken.
        Zero = 1'b0;
        cycle("beqn_fetch", V_FETCH);
        cycle("beqn_decode", V_DECODE);
        cycle("beqn_beq", V_BEQ_NT);

        // jal.
        set_instr(7'b1101111, 3'b000, 1'b0);
        Zero = 1'b1;
        cycle("jal_fetch", V_FETCH);
        check("jal_imm", {30'd0, ImmSrc}, 32'd3);
        cycle("jal_decode", V_DECODE);
        cycle("jal_jal", V_JAL);
        Zero = 1'b0;

        // Fetch stall then lw with one MEMREAD stall.
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        cycle("fst_fetch0", V_FSTALL);
        cycle("fst_fetch1", V_FSTALL);
        mem_ready = 1'b1;
        cycle("fst_fetch2", V_FETCH);
        cycle("fst_decode", V_DECODE);
        cycle("fst_memadr", V_MEMADR);
        mem_ready = 1'b0;
        cycle("fst_memrd0", V_MEMREAD);
        mem_ready = 1'b1;
        cycle("fst_memrd1", V_MEMREAD);
        cycle("fst_memwb", V_MEMWB);

        // Illegal opcode parks in TRAP.
        set_instr(7'b0000000, 3'b000, 1'b0);
        cycle("ill_fetch", V_FETCH);
        check("ill_imm", {30'd0, ImmSrc}, 32'd0);
        cycle("ill_decode", V_DECODE);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            Zero      = i[1];
            cycle($sformatf("ill_trap%0d", i), V_TRAP);
        end
        mem_ready = 1'b1;
        Zero      = 1'b0;

        // Reset out of TRAP, then reset in the middle of a stalled MEMWRITE.
        rst_n = 1'b0;
        #1;
        check("trap_rst", {17'd0, ctrl_word}, {17'd0, V_FETCH & 15'b0_1_1_0_1_11_11_11_111_1});
        #2;
        set_instr(7'b0100011, 3'b010, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("mrst_fetch", V_FETCH);
        cycle("mrst_decode", V_DECODE);
        cycle("mrst_memadr", V_MEMADR);
        mem_ready = 1'b0;
        #1;
        check("mrst_memwr", {31'd0, MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_memwr_drop", {31'd0, MemWrite}, 32'd0);
        check("mrst_word", {17'd0, ctrl_word}, {17'd0, V_FSTALL});
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        cycle("mrst_refetch", V_FETCH);
        cycle("mrst_redecode", V_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
